// File: rtl/hazard_ctrl_if.sv
// Hazard-control bus: decode, redirect and writeback inputs plus issue/stall/flush and status outputs.
interface hazard_ctrl_if;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_rs1_use;
    logic        id_rs2_use;
    logic [4:0]  id_rd;
    logic        id_rd_wr;
    logic        ex_redirect;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        issue;
    logic        stall;
    logic        flush;
    logic [2:0]  pend_cnt;
    logic [1:0]  state;
    logic        sb_err;
    logic [15:0] stall_cycles;
    logic [15:0] flush_cycles;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_use, id_rs2_use, id_rd, id_rd_wr,
               ex_redirect, wb_valid, wb_rd,
        input  issue, stall, flush, pend_cnt, state, sb_err, stall_cycles, flush_cycles
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_use, id_rs2_use, id_rd, id_rd_wr,
               ex_redirect, wb_valid, wb_rd,
        output issue, stall, flush, pend_cnt, state, sb_err, stall_cycles, flush_cycles
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Register scoreboard and issue/stall/flush control for an in-order pipeline.
// Define HAZARD_CTRL_STATS_EN to enable the saturating stall/flush cycle counters.
module hazard_ctrl #(
    parameter int unsigned NREG      = 32,
    parameter int unsigned MAX_PEND  = 4,
    parameter int unsigned FLUSH_CYC = 2
) (
    input logic         clk,
    input logic         reset,
    hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN = 2'b00, STALL = 2'b01, FLUSH = 2'b10} stateT;

    stateT           state, stateNxt;
    logic [1:0]      bubble, bubbleNxt;
    logic [NREG-1:0] sb, sbEff, sbNxt;
    logic [2:0]      pendCnt;
    logic            sbErr;
    logic            block, issueO, stallO, flushO;
    logic            doSet, doClr, errHit;

    // Writeback retiring this cycle is visible to decode (write-first bypass).
    always_comb begin
        sbEff = sb;
        if (bus.wb_valid) sbEff[bus.wb_rd] = 1'b0;
    end

    always_comb begin
        block = (bus.id_rs1_use && bus.id_rs1 != 5'd0 && sbEff[bus.id_rs1])
             || (bus.id_rs2_use && bus.id_rs2 != 5'd0 && sbEff[bus.id_rs2])
             || (bus.id_rd_wr   && bus.id_rd  != 5'd0 && sbEff[bus.id_rd])
             || (bus.id_rd_wr   && bus.id_rd  != 5'd0 && pendCnt == 3'(MAX_PEND));
    end

    // Output process: all handshake outputs are held low while reset is asserted.
    always_comb begin
        flushO = 1'b0;
        issueO = 1'b0;
        stallO = 1'b0;
        if (reset) begin
            flushO = bus.ex_redirect || (state == FLUSH);
            issueO = bus.id_valid && !block && !flushO;
            stallO = bus.id_valid &&  block && !flushO;
        end
    end

    always_comb begin
        stateNxt  = state;
        bubbleNxt = bubble;
        unique case (state)
            RUN: begin
                if (bus.ex_redirect) begin
                    stateNxt  = FLUSH;
                    bubbleNxt = 2'(FLUSH_CYC - 1);
                end else if (stallO) begin
                    stateNxt = STALL;
                end
            end
            STALL: begin
                if (bus.ex_redirect) begin
                    stateNxt  = FLUSH;
                    bubbleNxt = 2'(FLUSH_CYC - 1);
                end else if (!stallO) begin
                    stateNxt = RUN;
                end
            end
            FLUSH: begin
                if (bus.ex_redirect) begin
                    bubbleNxt = 2'(FLUSH_CYC - 1);
                end else if (bubble == 2'd0) begin
                    stateNxt = RUN;
                end else begin
                    bubbleNxt = bubble - 2'd1;
                end
            end
            default: stateNxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= RUN;
            bubble <= '0;
        end else begin
            state  <= stateNxt;
            bubble <= bubbleNxt;
        end
    end

    assign doSet  = issueO && bus.id_rd_wr && bus.id_rd != 5'd0;
    assign doClr  = bus.wb_valid && sb[bus.wb_rd];
    assign errHit = bus.wb_valid && bus.wb_rd != 5'd0 && !sb[bus.wb_rd];

    // Set is applied after clear so a same-edge issue to the retiring register keeps it pending.
    always_comb begin
        sbNxt = sb;
        if (doClr) sbNxt[bus.wb_rd] = 1'b0;
        if (doSet) sbNxt[bus.id_rd] = 1'b1;
        sbNxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sb      <= '0;
            pendCnt <= '0;
            sbErr   <= 1'b0;
        end else begin
            sb <= sbNxt;
            if (doSet && !doClr)      pendCnt <= pendCnt + 3'd1;
            else if (!doSet && doClr) pendCnt <= pendCnt - 3'd1;
            if (errHit) sbErr <= 1'b1;
        end
    end

`ifdef HAZARD_CTRL_STATS_EN
    logic [15:0] stallCnt, flushCnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (stallO && stallCnt != '1) stallCnt <= stallCnt + 16'd1;
            if (flushO && flushCnt != '1) flushCnt <= flushCnt + 16'd1;
        end
    end

    assign bus.stall_cycles = stallCnt;
    assign bus.flush_cycles = flushCnt;
`else
    assign bus.stall_cycles = '0;
    assign bus.flush_cycles = '0;
`endif

    assign bus.issue    = issueO;
    assign bus.stall    = stallO;
    assign bus.flush    = flushO;
    assign bus.pend_cnt = pendCnt;
    assign bus.state    = state;
    assign bus.sb_err   = sbErr;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: driver queues hand-computed expectations, monitor checks mid-cycle.
module tb_hazard_ctrl;
    logic clk;
    logic reset;
    hazard_ctrl_if bus();

    hazard_ctrl #(.NREG(32), .MAX_PEND(4), .FLUSH_CYC(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        issue;
        logic        stall;
        logic        flush;
        logic [1:0]  state;
        logic [2:0]  pend;
        logic        err;
        logic        chkStats;
        logic [15:0] sc;
        logic [15:0] fc;
    } expT;

    expT expQ[$];
    int  passed = 0;
    int  total  = 0;

`ifdef HAZARD_CTRL_STATS_EN
    logic        chkStats = 1'b0;
`else
    logic        chkStats = 1'b1;
`endif
    logic [15:0] expSc = '0;
    logic [15:0] expFc = '0;

    task automatic check(input string nm, input string fld, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s.%s got %0h expected %0h", nm, fld, got, exp);
    endtask

    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            expT e;
            e = expQ.pop_front();
            check(e.name, "issue", 16'(bus.issue),    16'(e.issue));
            check(e.name, "stall", 16'(bus.stall),    16'(e.stall));
            check(e.name, "flush", 16'(bus.flush),    16'(e.flush));
            check(e.name, "state", 16'(bus.state),    16'(e.state));
            check(e.name, "pend",  16'(bus.pend_cnt), 16'(e.pend));
            check(e.name, "err",   16'(bus.sb_err),   16'(e.err));
            if (e.chkStats) begin
                check(e.name, "stall_cycles", bus.stall_cycles, e.sc);
                check(e.name, "flush_cycles", bus.flush_cycles, e.fc);
            end
        end
    end

    task automatic drive(input logic rst, input logic v, input logic [4:0] rs1, input logic rs1u,
                         input logic [4:0] rs2, input logic rs2u, input logic [4:0] rd, input logic rdwr,
                         input logic redir, input logic wbv, input logic [4:0] wbrd);
        @(posedge clk);
        #1;
        reset           = rst;
        bus.id_valid    = v;
        bus.id_rs1      = rs1;
        bus.id_rs1_use  = rs1u;
        bus.id_rs2      = rs2;
        bus.id_rs2_use  = rs2u;
        bus.id_rd       = rd;
        bus.id_rd_wr    = rdwr;
        bus.ex_redirect = redir;
        bus.wb_valid    = wbv;
        bus.wb_rd       = wbrd;
    endtask

    // Args: name, reset, valid, rs1, rs1_use, rs2, rs2_use, rd, rd_wr, redirect, wb_valid, wb_rd,
    //       then expected issue, stall, flush, state, pend_cnt, sb_err.
    task automatic step(input string nm, input logic rst, input logic v, input logic [4:0] rs1, input logic rs1u,
                        input logic [4:0] rs2, input logic rs2u, input logic [4:0] rd, input logic rdwr,
                        input logic redir, input logic wbv, input logic [4:0] wbrd,
                        input logic ei, input logic es, input logic ef, input logic [1:0] est,
                        input logic [2:0] ep, input logic ee);
        expT e;
        drive(rst, v, rs1, rs1u, rs2, rs2u, rd, rdwr, redir, wbv, wbrd);
        e = '{nm, ei, es, ef, est, ep, ee, chkStats, expSc, expFc};
        expQ.push_back(e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs1_use = 0; bus.id_rs2 = 0; bus.id_rs2_use = 0;
        bus.id_rd = 0; bus.id_rd_wr = 0; bus.ex_redirect = 0; bus.wb_valid = 0; bus.wb_rd = 0;

        step("rst_hold", 0, 1, 0, 1, 0, 0, 3, 1, 1, 0, 0,   0, 0, 0, 2'd0, 3'd0, 0);
        // RAW on x5 resolved by same-cycle writeback
        step("raw_iss",  1, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0,   1, 0, 0, 2'd0, 3'd0, 0);
        step("raw_stl",  1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 2'd0, 3'd1, 0);
        step("raw_byp",  1, 1, 5, 1, 0, 0, 0, 0, 0, 1, 5,   1, 0, 0, 2'd1, 3'd1, 0);
        step("raw_run",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 2'd0, 3'd0, 0);
        // Pending-write limit
        step("pend_w1",  1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0,   1, 0, 0, 2'd0, 3'd0, 0);
        step("pend_w2",  1, 1, 0, 0, 0, 0, 2, 1, 0, 0, 0,   1, 0, 0, 2'd0, 3'd1, 0);
        step("pend_w3",  1, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0,   1, 0, 0, 2'd0, 3'd2, 0);
        step("pend_w4",  1, 1, 0, 0, 0, 0, 4, 1, 0, 0, 0,   1, 0, 0, 2'd0, 3'd3, 0);
        step("pend_ful", 1, 1, 0, 0, 0, 0, 6, 1, 0, 0, 0,   0, 1, 0, 2'd0, 3'd4, 0);
        step("pend_wb",  1, 1, 0, 0, 0, 0, 6, 1, 0, 1, 1,   0, 1, 0, 2'd1, 3'd4, 0);
        step("pend_iss", 1, 1, 0, 0, 0, 0, 6, 1, 0, 0, 0,   1, 0, 0, 2'd1, 3'd3, 0);
        step("pend_4",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 2'd0, 3'd4, 0);
        step("drain3",   1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3,   0, 0, 0, 2'd0, 3'd4, 0);
        step("drain4",   1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4,   0, 0, 0, 2'd0, 3'd3, 0);
        // Issue to the register retiring this edge: set wins, count holds
        step("setwin",   1, 1, 0, 0, 0, 0, 6, 1, 0, 1, 6,   1, 0, 0, 2'd0, 3'd2, 0);
        step("setwin_c", 1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 2'd0, 3'd2, 0);
        step("drain6",   1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6,   0, 0, 0, 2'd1, 3'd2, 0);
        step("drain2",   1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2,   0, 0, 0, 2'd0, 3'd1, 0);
        step("empty",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 2'd0, 3'd0, 0);
        // Source-use qualifiers
        step("rs_w7",    1, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0,   1, 0, 0, 2'd0, 3'd0, 0);
        step("rs1_nuse", 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 2'd0, 3'd1, 0);
        step("rs2_use",  1, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0,   0, 1, 0, 2'd0, 3'd1, 0);
        step("rs2_wb",   1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7,   0, 0, 0, 2'd1, 3'd1, 0);
        // Redirect in RUN: three flush cycles, flushed write never reaches sb
        step("rd_pulse", 1, 1, 0, 0, 0, 0, 8, 1, 1, 0, 0,   0, 0, 1, 2'd0, 3'd0, 0);
        step("rd_fl1",   1, 1, 0, 0, 0, 0, 8, 1, 0, 0, 0,   0, 0, 1, 2'd2, 3'd0, 0);
        step("rd_fl2",   1, 1, 0, 0, 0, 0, 8, 1, 0, 0, 0,   0, 0, 1, 2'd2, 3'd0, 0);
        step("rd_after", 1, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 2'd0, 3'd0, 0);
        // Re-extension by a second redirect
        step("ext_p1",   1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 1, 2'd0, 3'd0, 0);
        step("ext_f1",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 2'd2, 3'd0, 0);
        step("ext_p2",   1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 1, 2'd2, 3'd0, 0);
        step("ext_f2",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 2'd2, 3'd0, 0);
        step("ext_f3",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 2'd2, 3'd0, 0);
        step("ext_run",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 2'd0, 3'd0, 0);
        // Redirect out of STALL, writeback during FLUSH
        step("sr_w10",   1, 1, 0, 0, 0, 0, 10, 1, 0, 0, 0,  1, 0, 0, 2'd0, 3'd0, 0);
        step("sr_stl",   1, 1, 10, 1, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 2'd0, 3'd1, 0);
        step("sr_redir", 1, 1, 10, 1, 0, 0, 0, 0, 1, 0, 0,  0, 0, 1, 2'd1, 3'd1, 0);
        step("sr_fl1",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 2'd2, 3'd1, 0);
        step("sr_fl2wb", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 10,  0, 0, 1, 2'd2, 3'd1, 0);
        step("sr_run",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 2'd0, 3'd0, 0);
        // x0 handling and sticky error
        step("x0_wr",    1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0,   1, 0, 0, 2'd0, 3'd0, 0);
        step("x0_rd",    1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 2'd0, 3'd0, 0);
        step("err_wb9",  1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9,   0, 0, 0, 2'd0, 3'd0, 0);
        step("err_set",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 2'd0, 3'd0, 1);
        step("err_wb0",  1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 2'd0, 3'd0, 1);
        step("err_w5",   1, 1, 0, 0, 0, 0, 5, 1, 0, 1, 5,   1, 0, 0, 2'd0, 3'd0, 1);
        step("err_stl",  1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 2'd0, 3'd1, 1);
        step("err_stl2", 1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 2'd1, 3'd1, 1);
        // Asynchronous reset mid-STALL with only x5 pending
        step("arst",     0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 2'd0, 3'd0, 0);
        step("arst_rel", 1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 2'd0, 3'd0, 0);

`ifdef HAZARD_CTRL_STATS_EN
        step("st_w5",    1, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0,   1, 0, 0, 2'd0, 3'd0, 0);
        for (int i = 0; i < 70000; i++) drive(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        chkStats = 1'b1;
        expSc    = 16'hFFFF;
        expFc    = 16'h0000;
        step("st_sat",   1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 2'd1, 3'd1, 0);
`endif

        for (int i = 0; i < 5 && expQ.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        total++;
        if (expQ.size() == 0) passed++;
        else $display("FAIL drain got %0d pending expected 0", expQ.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
